// File: rtl/get_log_shift.sv
// Iterative natural log: unsigned Q23.23 in, signed ln(x) out in Q(16-y_shift).y_shift.
// Leading-one normalisation, bit-serial log2 by repeated squaring, then scale by ln2.
module get_log_shift #(
   parameter int          ITER    = 12,
   parameter logic [15:0] LN2_Q16 = 16'd45426
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [45:0] x,
   input  logic [3:0]  y_shift,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] y,
   output logic        err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  dbg_state
);

   localparam int CW = $clog2(ITER);
   localparam int LW = ITER + 6;
   localparam int PW = LW + 17;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NORM  = 3'd1,
      S_ITER  = 3'd2,
      S_SCALE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [45:0]       x_q, x_d;
   logic [3:0]        ys_q, ys_d;
   logic [5:0]        e_q, e_d;
   logic [23:0]       m_q, m_d;
   logic [ITER-1:0]   frac_q, frac_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [15:0]       y_q, y_d;
   logic              err_q, err_d;

   logic [5:0]        lead_pos;
   logic [23:0]       m_norm;
   logic [47:0]       sq;
   logic signed [LW-1:0] l_s;
   logic signed [PW-1:0] p_s;
   logic [PW-1:0]     mag;
   logic [PW-1:0]     rnd;
   logic [PW-1:0]     r;
   logic [5:0]        sh;
   logic [15:0]       y_scaled;

   // Datapath helpers shared by NORM, ITER and SCALE.
   always_comb begin
      lead_pos = 6'd0;
      for (int i = 0; i < 46; i++) begin
         if (x_q[i]) lead_pos = 6'(i);
      end
      m_norm = 24'((x_q << (6'd45 - lead_pos)) >> 22);
      sq     = 48'(m_q) * 48'(m_q);

      l_s = {e_q, frac_q};
      p_s = PW'(l_s) * PW'($signed({1'b0, LN2_Q16}));
      mag = p_s[PW-1] ? PW'(-p_s) : PW'(p_s);
      sh  = 6'(ITER + 16) - {2'b00, ys_q};
      rnd = PW'(1) << (sh - 6'd1);
      r   = (mag + rnd) >> sh;
      if (p_s[PW-1]) begin
         y_scaled = (r > PW'(32768)) ? 16'h8000 : (~r[15:0] + 16'd1);
      end else begin
         y_scaled = (r > PW'(32767)) ? 16'h7FFF : r[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      ys_d    = ys_q;
      e_d     = e_q;
      m_d     = m_q;
      frac_d  = frac_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d  = x;
               ys_d = y_shift;
               if (x == 46'd0) begin
                  y_d     = 16'h8000;
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_NORM;
               end
            end
         end
         S_NORM: begin
            e_d     = lead_pos - 6'd23;
            m_d     = m_norm;
            frac_d  = '0;
            cnt_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            // Squaring doubles log2(m); a carry into bit 47 means the next fraction bit is 1.
            m_d    = sq[47] ? 24'(sq >> 24) : 24'(sq >> 23);
            frac_d = {frac_q[ITER-2:0], sq[47]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) state_d = S_SCALE;
         end
         S_SCALE: begin
            y_d     = y_scaled;
            err_d   = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         ys_q    <= '0;
         e_q     <= '0;
         m_q     <= '0;
         frac_q  <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         ys_q    <= ys_d;
         e_q     <= e_d;
         m_q     <= m_d;
         frac_q  <= frac_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   // Handshake: a transfer happens on any edge where valid and ready are both high.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign y         = y_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule
